// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared defaults and requester-id encoding for the instruction memory arbiter
package imem_arbiter_pkg;
  localparam int DEPTH_LOG2_DEF = 10;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic {REQ_FETCH = 1'b0, REQ_LOADER = 1'b1} req_id_t;
endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch/loader request-response channels plus the single-port memory bus
// slave: arbiter side (takes requests and mem_rdata, drives ready/responses/memory controls)
// master: requester/memory side
interface imem_arbiter_if import imem_arbiter_pkg::*; #(parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF);
  logic f_req_valid;
  logic [31:0] f_req_addr;
  logic f_req_ready;
  logic f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic f_rsp_err;
  logic l_req_valid;
  logic l_req_we;
  logic [31:0] l_req_addr;
  logic [31:0] l_req_wdata;
  logic l_req_ready;
  logic l_rsp_valid;
  logic [31:0] l_rsp_data;
  logic l_rsp_err;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input f_req_valid, f_req_addr, l_req_valid, l_req_we, l_req_addr, l_req_wdata, mem_rdata,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_addr, mem_we, mem_wdata
  );
  modport master (
    output f_req_valid, f_req_addr, l_req_valid, l_req_we, l_req_addr, l_req_wdata, mem_rdata,
    input f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_addr_check.sv
// imem_addr_check: flags a byte address that is not word aligned or lies beyond the memory
// ports: addr (byte address in), err (misaligned or out of range)
module imem_addr_check import imem_arbiter_pkg::*; #(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic [31:0] addr,
  output logic        err
);
  assign err = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: two-requester (fetch, loader) arbiter onto one combinational-read memory
// ports: clk, reset_n (async active-low), bus (imem_arbiter_if.slave: both request/response
// channels and the memory address/write/read signals)
module imem_arbiter import imem_arbiter_pkg::*; #(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic clk,
  input logic reset_n,
  imem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  logic f_err, l_err, l_force, f_gnt, l_gnt;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0] wdata_q, rsp_data;
  logic rsp_valid, rsp_err;
  req_id_t rsp_id;
  imem_addr_check #(.DEPTH_LOG2(DEPTH_LOG2)) u_f_chk (.addr(bus.f_req_addr), .err(f_err));
  imem_addr_check #(.DEPTH_LOG2(DEPTH_LOG2)) u_l_chk (.addr(bus.l_req_addr), .err(l_err));
  always_comb begin
    l_force = bus.l_req_valid && (starve == SW'(STARVE_MAX));
    f_gnt = reset_n && bus.f_req_valid && !l_force;
    l_gnt = reset_n && bus.l_req_valid && !f_gnt;
    bus.f_req_ready = f_gnt;
    bus.l_req_ready = l_gnt;
    bus.mem_addr = f_gnt ? bus.f_req_addr[DEPTH_LOG2+1:2] : l_gnt ? bus.l_req_addr[DEPTH_LOG2+1:2] : addr_q;
    bus.mem_we = l_gnt && bus.l_req_we && !l_err;
    bus.mem_wdata = l_gnt ? bus.l_req_wdata : wdata_q;
    bus.f_rsp_valid = rsp_valid && (rsp_id == REQ_FETCH);
    bus.f_rsp_err = bus.f_rsp_valid && rsp_err;
    bus.f_rsp_data = bus.f_rsp_valid ? rsp_data : '0;
    bus.l_rsp_valid = rsp_valid && (rsp_id == REQ_LOADER);
    bus.l_rsp_err = bus.l_rsp_valid && rsp_err;
    bus.l_rsp_data = bus.l_rsp_valid ? rsp_data : '0;
  end
  // One response register is shared: at most one grant per cycle, rsp_id routes it back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_id <= REQ_FETCH;
      rsp_data <= '0;
    end else begin
      starve <= (!bus.l_req_valid || l_gnt) ? '0 : (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
      if (f_gnt || l_gnt) addr_q <= bus.mem_addr;
      if (l_gnt) wdata_q <= bus.l_req_wdata;
      rsp_valid <= f_gnt || l_gnt;
      rsp_id <= l_gnt ? REQ_LOADER : REQ_FETCH;
      rsp_err <= f_gnt ? f_err : (l_gnt && l_err);
      rsp_data <= ((f_gnt && !f_err) || (l_gnt && !l_err && !bus.l_req_we)) ? bus.mem_rdata : '0;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed vector table, reset corner case and randomized traffic vs a reference model
module tb_imem_arbiter;
  localparam int DL = 10;
  localparam int SMAX = 4;
  localparam int WORDS = 1 << DL;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic cur_fv, cur_lv, cur_lwe;
  logic [31:0] cur_fa, cur_la, cur_lwd;
  int starve_m = 0;
  bit pf = 0, pl = 0, perr = 0;
  logic [31:0] pdata = '0;
  bit eg_f, eg_l;
  typedef struct {
    logic fv; logic [31:0] fa; logic lv; logic lwe; logic [31:0] la; logic [31:0] lwd;
    logic e_fr; logic e_lr; logic e_we; logic e_fv; logic e_fe; logic e_lv; logic e_le; logic [31:0] e_fd;
  } vec_t;
  vec_t tbl [14];
  imem_arbiter_if #(.DEPTH_LOG2(DL)) bus ();
  imem_arbiter #(.DEPTH_LOG2(DL), .STARVE_MAX(SMAX)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (!reset_n) for (int i = 0; i < WORDS; i++) mem[i] <= 32'h1000_0000 + i;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * WORDS);
  endfunction
  function automatic logic [31:0] widx(input logic [31:0] a);
    return (a / 4) % WORDS;
  endfunction
  function automatic logic [31:0] gen_addr();
    int r = $urandom_range(0, 19);
    if (r == 0) return $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
    if (r == 1) return 4 * WORDS + $urandom_range(0, 1000) * 4;
    return $urandom_range(0, 31) * 4;
  endfunction
  task automatic init_ref();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h1000_0000 + i;
    starve_m = 0;
    pf = 0;
    pl = 0;
  endtask
  task automatic drive(input logic fv, input logic [31:0] fa, input logic lv, input logic lwe,
                       input logic [31:0] la, input logic [31:0] lwd);
    cur_fv = fv; cur_fa = fa; cur_lv = lv; cur_lwe = lwe; cur_la = la; cur_lwd = lwd;
    bus.f_req_valid = fv; bus.f_req_addr = fa;
    bus.l_req_valid = lv; bus.l_req_we = lwe; bus.l_req_addr = la; bus.l_req_wdata = lwd;
  endtask
  task automatic model_check();
    bit force_l = cur_lv && (starve_m == SMAX);
    bit exp_we;
    eg_f = cur_fv && !force_l;
    eg_l = cur_lv && !eg_f;
    exp_we = eg_l && cur_lwe && !bad(cur_la);
    chk("f_req_ready", bus.f_req_ready, eg_f);
    chk("l_req_ready", bus.l_req_ready, eg_l);
    chk("mem_we", bus.mem_we, exp_we);
    if (eg_f) chk("mem_addr_f", bus.mem_addr, widx(cur_fa));
    if (eg_l) chk("mem_addr_l", bus.mem_addr, widx(cur_la));
    if (exp_we) chk("mem_wdata", bus.mem_wdata, cur_lwd);
    chk("f_rsp_valid", bus.f_rsp_valid, pf);
    chk("f_rsp_err", bus.f_rsp_err, pf && perr);
    if (pf) chk("f_rsp_data", bus.f_rsp_data, pdata);
    chk("l_rsp_valid", bus.l_rsp_valid, pl);
    chk("l_rsp_err", bus.l_rsp_err, pl && perr);
    if (pl) chk("l_rsp_data", bus.l_rsp_data, pdata);
  endtask
  task automatic model_advance();
    pf = eg_f;
    pl = eg_l;
    perr = eg_f ? bad(cur_fa) : (eg_l && bad(cur_la));
    pdata = eg_f ? (bad(cur_fa) ? 32'd0 : ref_mem[widx(cur_fa)])
                 : (eg_l && !bad(cur_la) && !cur_lwe) ? ref_mem[widx(cur_la)] : 32'd0;
    if (eg_l && cur_lwe && !bad(cur_la)) ref_mem[widx(cur_la)] = cur_lwd;
    starve_m = (!cur_lv || eg_l) ? 0 : (starve_m < SMAX ? starve_m + 1 : SMAX);
  endtask
  task automatic step(input logic fv, input logic [31:0] fa, input logic lv, input logic lwe,
                      input logic [31:0] la, input logic [31:0] lwd);
    drive(fv, fa, lv, lwe, la, lwd);
    @(negedge clk);
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 32'h0,  0, 0, 32'h0,    32'h0,        1, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 32'h4,  0, 0, 32'h0,    32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h1000_0000};
    tbl[2]  = '{1, 32'h8,  0, 0, 32'h0,    32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h1000_0001};
    tbl[3]  = '{0, 32'h0,  1, 1, 32'h10,   32'hDEADBEEF, 0, 1, 1, 1, 0, 0, 0, 32'h1000_0002};
    tbl[4]  = '{1, 32'h10, 0, 0, 32'h0,    32'h0,        1, 0, 0, 0, 0, 1, 0, 32'h0};
    tbl[5]  = '{1, 32'h6,  0, 0, 32'h0,    32'h0,        1, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF};
    tbl[6]  = '{0, 32'h0,  1, 1, 32'h1000, 32'h12345678, 0, 1, 0, 1, 1, 0, 0, 32'h0};
    tbl[7]  = '{1, 32'h0,  1, 0, 32'h8,    32'h0,        1, 0, 0, 0, 0, 1, 1, 32'h0};
    tbl[8]  = '{1, 32'h0,  1, 0, 32'h8,    32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h1000_0000};
    tbl[9]  = '{1, 32'h0,  1, 0, 32'h8,    32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h1000_0000};
    tbl[10] = '{1, 32'h0,  1, 0, 32'h8,    32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h1000_0000};
    tbl[11] = '{1, 32'h0,  1, 0, 32'h8,    32'h0,        0, 1, 0, 1, 0, 0, 0, 32'h1000_0000};
    tbl[12] = '{1, 32'h0,  1, 0, 32'h8,    32'h0,        1, 0, 0, 0, 0, 1, 0, 32'h0};
    tbl[13] = '{0, 32'h0,  0, 0, 32'h0,    32'h0,        0, 0, 0, 1, 0, 0, 0, 32'h1000_0000};
    init_ref();
    drive(1, 32'h0, 1, 1, 32'h4, 32'h55);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_f_ready", bus.f_req_ready, 0);
    chk("rst_l_ready", bus.l_req_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_f_rsp", {bus.f_rsp_valid, bus.f_rsp_err, bus.f_rsp_data}, 0);
    chk("rst_l_rsp", {bus.l_rsp_valid, bus.l_rsp_err, bus.l_rsp_data}, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].fv, tbl[i].fa, tbl[i].lv, tbl[i].lwe, tbl[i].la, tbl[i].lwd);
      @(negedge clk);
      model_check();
      chk($sformatf("v%0d_f_ready", i), bus.f_req_ready, tbl[i].e_fr);
      chk($sformatf("v%0d_l_ready", i), bus.l_req_ready, tbl[i].e_lr);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, tbl[i].e_we);
      chk($sformatf("v%0d_f_rsp_valid", i), bus.f_rsp_valid, tbl[i].e_fv);
      chk($sformatf("v%0d_f_rsp_err", i), bus.f_rsp_err, tbl[i].e_fe);
      chk($sformatf("v%0d_l_rsp_valid", i), bus.l_rsp_valid, tbl[i].e_lv);
      chk($sformatf("v%0d_l_rsp_err", i), bus.l_rsp_err, tbl[i].e_le);
      if (tbl[i].e_fv) chk($sformatf("v%0d_f_rsp_data", i), bus.f_rsp_data, tbl[i].e_fd);
      if (tbl[i].e_we) chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, 32'd4);
      model_advance();
      @(posedge clk);
      #1;
    end
    repeat (3) step(1, 32'h20, 1, 0, 32'h24, 32'h0);
    drive(1, 32'h20, 1, 0, 32'h24, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_f_ready", bus.f_req_ready, 0);
    chk("midrst_l_ready", bus.l_req_ready, 0);
    chk("midrst_f_rsp_valid", bus.f_rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_mem_wdata", bus.mem_wdata, 0);
    drive(0, 0, 0, 0, 0, 0);
    init_ref();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 32'h0, 0, 0, 32'h0, 32'h0);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (6) step(1, 32'h4, 1, 0, 32'h8, 32'h0);
    for (int n = 0; n < 2000; n++)
      step($urandom_range(0, 3) != 0, gen_addr(), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           gen_addr(), $urandom());
    step(0, 32'h0, 0, 0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
